tone_detector: RTL and testbench

Receive-side counterpart of the sound/alarm tone generator in wb_sonido. It samples an asynchronous square-wave input, measures the spacing between its edges, and checks that spacing against an expected half-period within a tolerance. After MATCH_N consecutive matching half-periods it asserts tone_present. Used for loopback self-test of the alarm output and for detecting an external beeper.

---
 rtl/tone_detector_pkg.sv | 16 +
 rtl/tone_detector_if.sv | 44 ++++
 rtl/tone_detector_sync_edge.sv | 28 ++
 rtl/tone_detector.sv | 138 +++++++++++++
 tb/tb_tone_detector.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tone_detector_pkg.sv
// Shared state encoding and default timing constants for the tone detector.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } tone_state_t;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_HALF_PERIOD = 63776;
  localparam int DEF_TOL         = 1024;
  localparam int DEF_MATCH_N     = 4;
  localparam int DEF_TIMEOUT     = 255104;

endpackage

// File: rtl/tone_detector_if.sv
// Signal bundle between the tone detector and its user.
// TONE_DETECTOR_IRQ_EN adds the irq / irq_ack pair.
interface tone_detector_if #(
  parameter int CNT_W = tone_pkg::DEF_CNT_W
) ();

  logic             tone_in;
  logic             tone_present;
  logic [CNT_W-1:0] half_period;
  logic             edge_stb;
  logic [3:0]       match_cnt;
`ifdef TONE_DETECTOR_IRQ_EN
  logic             irq;
  logic             irq_ack;
`endif

  // master is the detector, slave is whoever drives the tone and reads status
  modport master (
    input  tone_in,
    output tone_present,
    output half_period,
    output edge_stb,
    output match_cnt
`ifdef TONE_DETECTOR_IRQ_EN
    ,
    output irq,
    input  irq_ack
`endif
  );

  modport slave (
    output tone_in,
    input  tone_present,
    input  half_period,
    input  edge_stb,
    input  match_cnt
`ifdef TONE_DETECTOR_IRQ_EN
    ,
    input  irq,
    output irq_ack
`endif
  );

endinterface

// File: rtl/tone_detector_sync_edge.sv
// Two-flop synchroniser for the asynchronous tone input plus a registered
// any-edge strobe, which rises on the third clk edge after a transition.
module tone_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_stb
);

  logic sync1;
  logic sync2;
  logic delayed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      delayed  <= 1'b0;
      edge_stb <= 1'b0;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      delayed  <= sync2;
      edge_stb <= sync2 ^ delayed;
    end
  end

endmodule

// File: rtl/tone_detector.sv
// Measures edge spacing of a square wave and locks when MATCH_N consecutive
// half-periods fall within TOL of HALF_PERIOD. TONE_DETECTOR_IRQ_EN adds a sticky irq.
module tone_detector
  import tone_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int TOL         = DEF_TOL,
  parameter int MATCH_N     = DEF_MATCH_N,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  tone_detector_if.master bus
);

  localparam logic [CNT_W:0]   HALF_EXT    = (CNT_W+1)'(HALF_PERIOD);
  localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [3:0]       MATCH_LIM   = 4'(MATCH_N);

  tone_state_t      state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] half_period_q;
  logic [3:0]       match_cnt_q;
  logic [3:0]       next_cnt;
  logic             tone_present_q;
  logic             edge_stb;
  logic [CNT_W:0]   measured_ext;
  logic [CNT_W:0]   deviation;
  logic             is_match;
  logic             timed_out;

  tone_sync_edge u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .din      (bus.tone_in),
    .edge_stb (edge_stb)
  );

  // Counter holds cycles since the last edge; its pre-reload value is the measurement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
    end else if (edge_stb) begin
      counter <= CNT_W'(1);
    end else if (counter != '1) begin
      counter <= counter + 1'b1;
    end
  end

  // One extra bit so the absolute deviation never wraps near the counter limits
  always_comb begin
    measured_ext = {1'b0, counter};
    if (measured_ext >= HALF_EXT) begin
      deviation = measured_ext - HALF_EXT;
    end else begin
      deviation = HALF_EXT - measured_ext;
    end
  end

  assign is_match  = (deviation <= TOL_EXT);
  assign timed_out = (counter >= TIMEOUT_CNT);
  assign next_cnt  = match_cnt_q + 4'd1;

  // An edge always takes priority over a timeout landing in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      tone_present_q <= 1'b0;
      half_period_q  <= '0;
      match_cnt_q    <= '0;
    end else if (edge_stb) begin
      case (state)
        IDLE: begin
          state <= ACQUIRE;
        end
        ACQUIRE: begin
          half_period_q <= counter;
          if (is_match) begin
            match_cnt_q <= next_cnt;
            if (next_cnt == MATCH_LIM) begin
              state          <= LOCKED;
              tone_present_q <= 1'b1;
            end
          end else begin
            match_cnt_q <= '0;
          end
        end
        LOCKED: begin
          half_period_q <= counter;
          if (!is_match) begin
            state          <= ACQUIRE;
            match_cnt_q    <= '0;
            tone_present_q <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          match_cnt_q    <= '0;
          tone_present_q <= 1'b0;
        end
      endcase
    end else if (state != IDLE && timed_out) begin
      state          <= IDLE;
      match_cnt_q    <= '0;
      tone_present_q <= 1'b0;
    end
  end

  assign bus.tone_present = tone_present_q;
  assign bus.half_period  = half_period_q;
  assign bus.edge_stb     = edge_stb;
  assign bus.match_cnt    = match_cnt_q;

`ifdef TONE_DETECTOR_IRQ_EN
  logic lock_evt;
  logic drop_evt;
  logic irq_q;

  // Flag the same clock edge on which tone_present is about to change
  assign lock_evt = edge_stb && (state == ACQUIRE) && is_match && (next_cnt == MATCH_LIM);
  assign drop_evt = tone_present_q && ((edge_stb && !is_match) || (!edge_stb && timed_out));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else if (lock_evt || drop_evt) begin
      irq_q <= 1'b1;
    end else if (bus.irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector with a short 100-cycle half-period.
// Define TONE_DETECTOR_IRQ_EN to also exercise irq / irq_ack.
`timescale 1ns/1ps
module tb_tone_detector;

  localparam int CNT_W   = 32;
  localparam int HP      = 100;
  localparam int TOL     = 4;
  localparam int MATCH_N = 4;
  localparam int TIMEOUT = 400;

  typedef struct {
    int hp;
    int cnt;
    int present;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cycle = 0;
  int   last_toggle = 0;
  int   last_stb_cycle = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   m_state = 0;
  int   m_cnt = 0;
  int   m_hp = 0;
  int   m_present = 0;
  exp_t exp_q[$];
  exp_t cur_exp;

  tone_detector_if #(.CNT_W(CNT_W)) bus ();

  tone_detector #(
    .CNT_W       (CNT_W),
    .HALF_PERIOD (HP),
    .TOL         (TOL),
    .MATCH_N     (MATCH_N),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Toggle tone_in 'gap' cycles after the previous toggle and predict the detector response
  task automatic applyStimulus(input int gap);
    int  actual_gap;
    bit  ok;
    do begin
      @(posedge clk);
      #1;
    end while (cycle - last_toggle < gap);
    actual_gap = cycle - last_toggle;
    if (m_state != 0 && actual_gap > TIMEOUT) begin
      m_state = 0; m_cnt = 0; m_present = 0;
    end
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      m_hp = actual_gap;
      ok = (actual_gap >= HP - TOL) && (actual_gap <= HP + TOL);
      if (!ok) begin
        m_state = 1; m_cnt = 0; m_present = 0;
      end else if (m_state == 1) begin
        m_cnt++;
        if (m_cnt == MATCH_N) begin
          m_state = 2; m_present = 1;
        end
      end
    end
    exp_q.push_back('{m_hp, m_cnt, m_present});
    bus.tone_in = ~bus.tone_in;
    last_toggle = cycle;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    bus.tone_in = 1'b0;
    #1;
    checkOutput("rst_present", bus.tone_present, 0);
    checkOutput("rst_half_period", bus.half_period, 0);
    checkOutput("rst_match_cnt", bus.match_cnt, 0);
    checkOutput("rst_edge_stb", bus.edge_stb, 0);
`ifdef TONE_DETECTOR_IRQ_EN
    checkOutput("rst_irq", bus.irq, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_state = 0; m_cnt = 0; m_hp = 0; m_present = 0;
    last_toggle = cycle;
  endtask

  // Monitor: each edge_stb pops one prediction, checked the cycle after the strobe
  initial begin
    forever begin
      @(negedge clk);
      if (bus.edge_stb === 1'b1) begin
        last_stb_cycle = cycle;
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_edge", 1, 0);
        end else begin
          cur_exp = exp_q.pop_front();
          @(negedge clk);
          checkOutput("sb_half_period", bus.half_period, cur_exp.hp);
          checkOutput("sb_match_cnt", bus.match_cnt, cur_exp.cnt);
          checkOutput("sb_present", bus.tone_present, cur_exp.present);
          checkOutput("sb_stb_pulse", bus.edge_stb, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.tone_in = 1'b0;
`ifdef TONE_DETECTOR_IRQ_EN
    bus.irq_ack = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("init_present", bus.tone_present, 0);
    checkOutput("init_half_period", bus.half_period, 0);
    checkOutput("init_match_cnt", bus.match_cnt, 0);
    checkOutput("init_edge_stb", bus.edge_stb, 0);
`ifdef TONE_DETECTOR_IRQ_EN
    checkOutput("init_irq", bus.irq, 0);
`endif
    reset = 1'b1;
    last_toggle = cycle;

    // Ideal tone: arm, four matches, lock, then stay locked
    applyStimulus(20);
    for (int i = 0; i < 4; i++) applyStimulus(100);
`ifdef TONE_DETECTOR_IRQ_EN
    repeat (8) @(negedge clk);
    checkOutput("irq_on_lock", bus.irq, 1);
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    checkOutput("irq_acked", bus.irq, 0);
`endif
    for (int i = 0; i < 2; i++) applyStimulus(100);

    // One bad half-period unlocks, four good ones relock
    applyStimulus(150);
`ifdef TONE_DETECTOR_IRQ_EN
    begin
      int n;
      n = 0;
      while (bus.edge_stb !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) checkOutput("irq_stb_wait", 0, 1);
      bus.irq_ack = 1'b1;
      @(negedge clk);
      bus.irq_ack = 1'b0;
      checkOutput("irq_set_beats_ack", bus.irq, 1);
      checkOutput("irq_unlock_present", bus.tone_present, 0);
      @(negedge clk);
      bus.irq_ack = 1'b1;
      @(negedge clk);
      bus.irq_ack = 1'b0;
      checkOutput("irq_cleared", bus.irq, 0);
    end
`endif
    for (int i = 0; i < 4; i++) applyStimulus(100);

    // Tolerance edges: 96/104 lock, 95 and 105 reset the match count
    applyStimulus(150);
    applyStimulus(96);
    applyStimulus(104);
    applyStimulus(96);
    applyStimulus(104);
    applyStimulus(95);
    applyStimulus(100);
    applyStimulus(95);
    applyStimulus(100);
    applyStimulus(100);
    applyStimulus(105);
    for (int i = 0; i < 4; i++) applyStimulus(100);

    // Hold the input: lock must drop exactly TIMEOUT cycles after the last strobe
    repeat (10) @(negedge clk);
    while (cycle < last_stb_cycle + TIMEOUT) @(negedge clk);
    checkOutput("timeout_hold", bus.tone_present, 1);
    @(negedge clk);
    checkOutput("timeout_drop", bus.tone_present, 0);
    checkOutput("timeout_match_cnt", bus.match_cnt, 0);
    checkOutput("timeout_half_period", bus.half_period, HP);
    applyStimulus(450);
    for (int i = 0; i < 4; i++) applyStimulus(100);

    // Reset while locked, then the first edge only arms
    repeat (30) @(negedge clk);
    checkOutput("pre_reset_present", bus.tone_present, 1);
    pulseReset();
    applyStimulus(20);
    applyStimulus(100);
    applyStimulus(100);

    repeat (20) @(negedge clk);
    checkOutput("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
